// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// Each operation takes three states: operand capture, result capture, response hold.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_d,
  output logic [2:0]        rsp0_flags,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_d,
  output logic [2:0]        rsp1_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_d,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [SEL_W-1:0]  op_sel_q, op_sel_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [2:0]        flags_q, flags_d;
  logic              grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sel_q <= '0;
      res_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_sel_q <= op_sel_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    res_d      = res_q;
    flags_d    = flags_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    // rr_ptr only matters when both requesters are valid at once
    grant1     = req1_valid && (!req0_valid || rr_ptr_q);
    case (state_q)
      IDLE: begin
        req0_ready = req0_valid && !grant1;
        req1_ready = grant1;
        if (req0_valid || req1_valid) begin
          owner_d  = grant1;
          op_a_d   = grant1 ? req1_a   : req0_a;
          op_b_d   = grant1 ? req1_b   : req0_b;
          op_sel_d = grant1 ? req1_sel : req0_sel;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_d;
        flags_d = {alu_zero, alu_carry, alu_overflow};
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = !owner_q;
        rsp1_valid = owner_q;
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          rr_ptr_d = ~owner_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The shared ALU only ever sees registered operands
  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_sel    = op_sel_q;
  assign rsp0_d     = res_q;
  assign rsp1_d     = res_q;
  assign rsp0_flags = flags_q;
  assign rsp1_flags = flags_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural add/sub ALU attached.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_d, rsp1_d;
  logic [2:0]  rsp0_flags, rsp1_flags;
  logic [31:0] alu_a, alu_b, alu_d;
  logic [3:0]  alu_sel;
  logic        alu_zero, alu_carry, alu_overflow, busy;
  logic [32:0] alu_wide;
  logic [4:0]  st;
  int          n_tests = 0;
  int          n_fail  = 0;

  alu_arbiter #(.DATA_W(32), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_d(rsp0_d), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_d(rsp1_d), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_d(alu_d),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Team ALU: 0000 add, 0001 sub; carry is carry-out for add, borrow for sub
  always_comb begin
    alu_wide     = '0;
    alu_overflow = 1'b0;
    case (alu_sel)
      4'b0001: begin
        alu_wide     = {1'b0, alu_a} - {1'b0, alu_b};
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_wide[31] != alu_a[31]);
      end
      default: begin
        alu_wide     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_wide[31] != alu_a[31]);
      end
    endcase
  end
  assign alu_d     = alu_wide[31:0];
  assign alu_zero  = (alu_d == 32'd0);
  assign alu_carry = alu_wide[32];
  assign st        = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy};

  task tick;
    @(posedge clk);
    #1;
  endtask

  task clear_inputs;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_sel = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
  endtask

  task do_reset;
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task test_reset;
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    n_tests++;
    if (st !== 5'b0) begin n_fail++; $display("FAIL reset_status: got %b want 00000", st); end
    n_tests++;
    if ({rsp0_d, rsp1_d, rsp0_flags, rsp1_flags, alu_a, alu_b, alu_sel} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rsp0_d=%h rsp1_d=%h f0=%b f1=%b alu_a=%h alu_b=%h sel=%b want all 0",
               rsp0_d, rsp1_d, rsp0_flags, rsp1_flags, alu_a, alu_b, alu_sel);
    end
    tick();
    rst_n = 1;
    @(negedge clk);
    n_tests++;
    if (st !== 5'b0) begin n_fail++; $display("FAIL reset_release: got %b want 00000", st); end
    $display("[TB] reset checked");
  endtask

  task test_single;
    tick();
    req0_valid = 1; req0_a = 32'd5; req0_b = 32'd3; req0_sel = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (st !== 5'b10000) begin n_fail++; $display("FAIL single_grant: got %b want 10000", st); end
    tick();
    req0_valid = 0;
    @(negedge clk);
    n_tests++;
    if ({st, alu_a, alu_b, alu_sel} !== {5'b00001, 32'd5, 32'd3, 4'b0000}) begin
      n_fail++;
      $display("FAIL single_exec: st=%b alu_a=%0d alu_b=%0d sel=%b want 00001 5 3 0000", st, alu_a, alu_b, alu_sel);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({st, rsp0_d, rsp0_flags} !== {5'b00101, 32'd8, 3'b000}) begin
      n_fail++;
      $display("FAIL single_rsp: st=%b d=%0d flags=%b want 00101 8 000", st, rsp0_d, rsp0_flags);
    end
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    @(negedge clk);
    n_tests++;
    if (st !== 5'b0) begin n_fail++; $display("FAIL single_done: got %b want 00000", st); end
    $display("[TB] single op req0 5+3 -> %0d flags %b", rsp0_d, rsp0_flags);
  endtask

  task test_tie;
    int g[3];
    int k;
    do_reset();
    k = 0;
    req0_valid = 1; req0_a = 32'd1;  req0_b = 32'd2; req0_sel = 4'b0000;
    req1_valid = 1; req1_a = 32'd10; req1_b = 32'd4; req1_sel = 4'b0001;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int c = 0; c < 20 && k < 3; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) begin
        n_tests++; n_fail++;
        $display("FAIL tie_two_ready: both ready high at cycle %0d", c);
      end
      if (rsp0_valid) begin
        n_tests++;
        if (rsp0_d !== 32'd3) begin n_fail++; $display("FAIL tie_rsp0: got %0d want 3", rsp0_d); end
      end
      if (rsp1_valid) begin
        n_tests++;
        if (rsp1_d !== 32'd6) begin n_fail++; $display("FAIL tie_rsp1: got %0d want 6", rsp1_d); end
      end
      if (req0_ready || req1_ready) begin
        g[k] = req1_ready ? 1 : 0;
        k++;
      end
      if (k < 3) tick();
    end
    n_tests++;
    if (k != 3 || g[0] != 0 || g[1] != 1 || g[2] != 0) begin
      n_fail++;
      $display("FAIL tie_order: got %0d grants %0d,%0d,%0d want 3 grants 0,1,0", k, g[0], g[1], g[2]);
    end
    // Drop both valids before the third grant is taken: no operation may start
    req0_valid = 0; req1_valid = 0;
    tick();
    @(negedge clk);
    n_tests++;
    if (st !== 5'b0) begin n_fail++; $display("FAIL tie_withdraw: got %b want 00000", st); end
    rsp0_ready = 0; rsp1_ready = 0;
    $display("[TB] tie grants %0d,%0d,%0d", g[0], g[1], g[2]);
  endtask

  task test_flags;
    logic [31:0] va [2];
    logic [31:0] vb [2];
    logic [3:0]  vs [2];
    logic [31:0] vd [2];
    logic [2:0]  vf [2];
    va[0] = 32'd5;        vb[0] = 32'd5; vs[0] = 4'b0001; vd[0] = 32'd0;        vf[0] = 3'b100;
    va[1] = 32'h7FFFFFFF; vb[1] = 32'd1; vs[1] = 4'b0000; vd[1] = 32'h80000000; vf[1] = 3'b001;
    for (int i = 0; i < 2; i++) begin
      tick();
      req1_valid = 1; req1_a = va[i]; req1_b = vb[i]; req1_sel = vs[i];
      @(negedge clk);
      n_tests++;
      if (st !== 5'b01000) begin n_fail++; $display("FAIL flags_grant%0d: got %b want 01000", i, st); end
      tick();
      req1_valid = 0;
      tick();
      @(negedge clk);
      n_tests++;
      if ({st, rsp1_d, rsp1_flags} !== {5'b00011, vd[i], vf[i]}) begin
        n_fail++;
        $display("FAIL flags_rsp%0d: st=%b d=%h flags=%b want 00011 %h %b", i, st, rsp1_d, rsp1_flags, vd[i], vf[i]);
      end
      rsp1_ready = 1;
      tick();
      rsp1_ready = 0;
      $display("[TB] flags op%0d req1 -> d=%h flags=%b", i, rsp1_d, rsp1_flags);
    end
  endtask

  task test_back_to_back;
    int acc[4];
    int k;
    k = 0;
    tick();
    req1_valid = 1; req1_a = 32'd20; req1_b = 32'd22; req1_sel = 4'b0000;
    rsp1_ready = 1;
    for (int c = 0; c < 30 && k < 4; c++) begin
      @(negedge clk);
      if (req0_ready) begin n_tests++; n_fail++; $display("FAIL b2b_req0_ready: high at cycle %0d", c); end
      if (rsp1_valid) begin
        n_tests++;
        if (rsp1_d !== 32'd42) begin n_fail++; $display("FAIL b2b_rsp: got %0d want 42", rsp1_d); end
      end
      if (req1_ready) begin acc[k] = c; k++; end
      if (k < 4) tick();
    end
    n_tests++;
    if (k != 4 || acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3 || acc[3] - acc[2] != 3) begin
      n_fail++;
      $display("FAIL b2b_spacing: %0d accepts at %0d,%0d,%0d,%0d want 4 spaced by 3", k, acc[0], acc[1], acc[2], acc[3]);
    end
    req1_valid = 0;
    tick();
    rsp1_ready = 0;
    $display("[TB] back-to-back req1 accepts at cycles %0d,%0d,%0d,%0d", acc[0], acc[1], acc[2], acc[3]);
  endtask

  task test_stall;
    tick();
    req0_valid = 1; req0_a = 32'd100; req0_b = 32'd1; req0_sel = 4'b0001;
    rsp0_ready = 0; rsp1_ready = 1;
    @(negedge clk);
    n_tests++;
    if (st !== 5'b10000) begin n_fail++; $display("FAIL stall_grant: got %b want 10000", st); end
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_a = 32'd7; req1_b = 32'd8; req1_sel = 4'b0000;
    tick();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if ({st, rsp0_d, rsp0_flags} !== {5'b00101, 32'd99, 3'b000}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: st=%b d=%0d flags=%b want 00101 99 000", c, st, rsp0_d, rsp0_flags);
      end
      tick();
    end
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    @(negedge clk);
    n_tests++;
    if (st !== 5'b01000) begin n_fail++; $display("FAIL stall_next_grant: got %b want 01000", st); end
    tick();
    req1_valid = 0;
    tick();
    @(negedge clk);
    n_tests++;
    if ({st, rsp1_d} !== {5'b00011, 32'd15}) begin
      n_fail++;
      $display("FAIL stall_req1_rsp: st=%b d=%0d want 00011 15", st, rsp1_d);
    end
    tick();
    rsp1_ready = 0;
    $display("[TB] stall 10 cycles held rsp0, then req1 -> %0d", rsp1_d);
  endtask

  task test_reset_midop;
    tick();
    req0_valid = 1; req0_a = 32'd2; req0_b = 32'd2; req0_sel = 4'b0000;
    rsp0_ready = 1;
    // First op completes (rr_ptr moves to 1); the held valid starts a second op
    tick();
    tick();
    tick();
    tick();
    n_tests++;
    if (st !== 5'b00001) begin n_fail++; $display("FAIL midop_exec: got %b want 00001", st); end
    #2;
    rst_n = 0;
    req0_valid = 0; rsp0_ready = 0;
    #1;
    n_tests++;
    if ({st, rsp0_d, rsp1_d, rsp0_flags, rsp1_flags, alu_a, alu_b, alu_sel} !== '0) begin
      n_fail++;
      $display("FAIL midop_async: st=%b rsp0_d=%h alu_a=%h alu_b=%h want all 0", st, rsp0_d, alu_a, alu_b);
    end
    tick();
    rst_n = 1;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (st !== 5'b0) begin n_fail++; $display("FAIL midop_no_rsp%0d: got %b want 00000", c, st); end
      tick();
    end
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    n_tests++;
    if (st !== 5'b10000) begin n_fail++; $display("FAIL midop_tie: got %b want 10000", st); end
    clear_inputs();
    $display("[TB] reset mid-op discarded, next tie grants req0");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_tie();
    test_flags();
    test_back_to_back();
    test_stall();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, 32, operand/result width; SHALL be fixed at 32 for this release.
REQ-002 Parameter SEL_W, 4, ALU operation-select width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-006 req0_ready / req1_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  DATA_W  operands A, B from requester N.
REQ-008 req0_sel / req1_sel  input  SEL_W  ALU select from requester N, passed through unmodified.
REQ-009 rsp0_valid / rsp1_valid  output  1  result for requester N is held.
REQ-010 rsp0_ready / rsp1_ready  input  1  requester N consumes its result.
REQ-011 rsp0_d / rsp1_d  output  DATA_W  result value.
REQ-012 rsp0_flags / rsp1_flags  output  3  {Zero, Carry, Overflow} captured with the result.
REQ-013 alu_a, alu_b  output  DATA_W  operands to the shared ALU.
REQ-014 alu_sel  output  SEL_W  select to the shared ALU.
REQ-015 alu_d  input  DATA_W  combinational ALU result.
REQ-016 alu_zero, alu_carry, alu_overflow  input  1  combinational ALU flags.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-019 Grant in IDLE: only one valid -> grant it; both valid -> grant requester named by rr_ptr; none -> stay IDLE.
REQ-020 reqN_ready SHALL be combinational, high only in IDLE for the granted requester; at most one ready is high per cycle.
REQ-021 Acceptance = reqN_valid && reqN_ready; on acceptance the a, b, sel operands and owner ID SHALL be registered and the FSM SHALL go IDLE -> EXEC.
REQ-022 alu_a, alu_b and alu_sel SHALL be driven only from the operand registers, never directly from request inputs.
REQ-023 In EXEC (one cycle) alu_d and the three flags SHALL be captured into the result registers; the FSM SHALL go EXEC -> RESP.
REQ-024 In RESP, rspN_valid SHALL be high for the owner only; rspN_d and rspN_flags SHALL hold stable until the handshake.
REQ-025 rspN_valid && rspN_ready SHALL complete the operation: set rr_ptr to the other requester, then go RESP -> IDLE.
REQ-026 Latency SHALL be acceptance at cycle T, rsp_valid at T+2, minimum 3 cycles per operation; operations SHALL never overlap.
REQ-027 rsp_ready held low SHALL stall in RESP indefinitely; both req_ready signals stay low for the whole stall.
REQ-028 A single active requester SHALL be served back-to-back; rr_ptr only breaks ties.
REQ-029 Non-owner rsp_valid SHALL stay 0; a non-owner rsp_ready SHALL be ignored.
REQ-030 Requesters hold valid and operands until accepted; a valid dropped before acceptance SHALL cause no operation.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, rr_ptr=0, and zero all operand/result registers.
REQ-032 After reset all outputs SHALL read 0: req*_ready, rsp*_valid, rsp*_d, rsp*_flags, alu_a, alu_b, alu_sel, busy.
REQ-033 Reset during EXEC or RESP SHALL discard the in-flight operation; no response for it SHALL ever appear.

Verification (bench connects the team ALU: sel 4'b0000 = add, 4'b0001 = sub)
REQ-034 Single op: req0 a=5, b=3, sel=0000 accepted at T -> rsp0_valid at T+2, rsp0_d=8, flags=000; busy high T+1..handshake.
REQ-035 Tie: req0 and req1 valid together after reset -> req0 granted first; req1 granted next; a further tie grants req0 again (alternation).
REQ-036 Flags: req1 a=5, b=5, sel=0001 -> rsp1_d=0, Zero=1; a=32'h7FFFFFFF, b=1, sel=0000 -> rsp1_d=32'h80000000, Overflow=1.
REQ-037 Stall: rsp0_ready low 10 cycles with req1_valid high -> rsp0_d stable, req1_ready low throughout; req1 accepted the cycle after rsp0 handshake plus IDLE.
REQ-038 Reset mid-op: assert rst_n=0 in EXEC -> all outputs 0 asynchronously, no rsp after release, next tie grants req0.
